// File: rtl/mapper_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mapper_mem_pkg
// Description : Shared types and constants for the mapper memory sequencer.
//               Contents: FSM state type, arbitration grant type, default
//               address width and the saturating wait-counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mapper_mem_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        G_CPU = 1'b0,
        G_PPU = 1'b1
    } grant_t;

    localparam int DEFAULT_ADDR_W = 22;

    // CPU starvation counter width and its saturation value
    localparam int              WAIT_W   = 4;
    localparam logic [WAIT_W-1:0] WAIT_MAX = 4'd15;

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (v == WAIT_MAX) ? v : v + WAIT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_latch.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_latch
// Description : One-deep request holding register for one requester side
//               (CPU or PPU). Captures a single-cycle access strobe, holds it
//               until the memory cycle completes (or, for a suppressed
//               access, for exactly one cycle), returns read data and a
//               one-cycle done pulse, and flags requests that arrive while
//               the slot is still occupied.
// Ports       : clk, reset_n          - clock, async active-low reset
//               req/we/allow/addr/wdata - requester strobe and attributes
//               mem_complete, mem_rdata - memory cycle for this side ends now
//               mem_pending           - slot holds an access needing memory
//               lat_we/lat_addr/lat_wdata - held access attributes
//               rdata, done           - registered read data / done pulse
//               overrun_evt           - request dropped this cycle (pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_latch
    import mapper_mem_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic              allow,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    input  logic              mem_complete,
    input  logic [7:0]        mem_rdata,
    output logic              mem_pending,
    output logic              lat_we,
    output logic [ADDR_W-1:0] lat_addr,
    output logic [7:0]        lat_wdata,
    output logic [7:0]        rdata,
    output logic              done,
    output logic              overrun_evt
);

    logic pending;
    logic lat_allow;
    logic supp_complete;
    logic complete;
    logic capture;

    // A suppressed access never reaches the arbiter; it retires on the first
    // edge after capture.
    assign supp_complete = pending && !lat_allow;
    assign complete      = supp_complete || mem_complete;

    // A slot that is retiring on this edge is free for a new capture.
    assign capture       = req && (!pending || complete);
    assign overrun_evt   = req && pending && !complete;

    assign mem_pending   = pending && lat_allow;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending   <= 1'b0;
            lat_allow <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata     <= 8'hFF;
            done      <= 1'b0;
        end else begin
            done <= complete;
            if (capture) begin
                pending   <= 1'b1;
                lat_allow <= allow;
                lat_we    <= we;
                lat_addr  <= addr;
                lat_wdata <= wdata;
            end else if (complete) begin
                pending <= 1'b0;
            end
            if (mem_complete && !lat_we) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mapper_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mapper_mem_sequencer
// Description : Turns mapper-translated CPU (PRG) and PPU (CHR) accesses into
//               single-port memory transactions. One outstanding request per
//               side, PPU-first arbitration with a CPU starvation guard, and a
//               req/ack handshake toward the SDRAM controller.
// Ports       : clk, reset_n                      - clock, async active-low reset
//               cpu_req/we/allow/addr/wdata       - CPU access in
//               cpu_rdata, cpu_done               - CPU read data / completion
//               ppu_*                             - same for the PPU side
//               mem_req/we/addr/wdata             - memory request (held to ack)
//               mem_ack, mem_rdata                - memory acknowledge / data
//               overrun                           - sticky dropped-request flag
// Revision    : 1.0 - initial release
// ============================================================================
module mapper_mem_sequencer
    import mapper_mem_pkg::*;
#(
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_allow,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_done,
    input  logic              ppu_req,
    input  logic              ppu_we,
    input  logic              ppu_allow,
    input  logic [ADDR_W-1:0] ppu_addr,
    input  logic [7:0]        ppu_wdata,
    output logic [7:0]        ppu_rdata,
    output logic              ppu_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              overrun
);

    localparam logic [WAIT_W-1:0] STARVE_THR = WAIT_W'(STARVE_LIMIT);

    state_t            state;
    state_t            state_nx;
    grant_t            grant;
    grant_t            grant_nx;
    logic              issue;
    logic              finish;
    logic [WAIT_W-1:0] cpu_wait;
    logic              cpu_starved;

    logic              cpu_pend;
    logic              cpu_lat_we;
    logic [ADDR_W-1:0] cpu_lat_addr;
    logic [7:0]        cpu_lat_wdata;
    logic              cpu_ovr_evt;
    logic              cpu_complete;

    logic              ppu_pend;
    logic              ppu_lat_we;
    logic [ADDR_W-1:0] ppu_lat_addr;
    logic [7:0]        ppu_lat_wdata;
    logic              ppu_ovr_evt;
    logic              ppu_complete;

    assign cpu_complete = finish && (grant == G_CPU);
    assign ppu_complete = finish && (grant == G_PPU);
    assign cpu_starved  = (cpu_wait >= STARVE_THR);

    mem_port_latch #(
        .ADDR_W (ADDR_W)
    ) u_cpu_latch (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (cpu_req),
        .we           (cpu_we),
        .allow        (cpu_allow),
        .addr         (cpu_addr),
        .wdata        (cpu_wdata),
        .mem_complete (cpu_complete),
        .mem_rdata    (mem_rdata),
        .mem_pending  (cpu_pend),
        .lat_we       (cpu_lat_we),
        .lat_addr     (cpu_lat_addr),
        .lat_wdata    (cpu_lat_wdata),
        .rdata        (cpu_rdata),
        .done         (cpu_done),
        .overrun_evt  (cpu_ovr_evt)
    );

    mem_port_latch #(
        .ADDR_W (ADDR_W)
    ) u_ppu_latch (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (ppu_req),
        .we           (ppu_we),
        .allow        (ppu_allow),
        .addr         (ppu_addr),
        .wdata        (ppu_wdata),
        .mem_complete (ppu_complete),
        .mem_rdata    (mem_rdata),
        .mem_pending  (ppu_pend),
        .lat_we       (ppu_lat_we),
        .lat_addr     (ppu_lat_addr),
        .lat_wdata    (ppu_lat_wdata),
        .rdata        (ppu_rdata),
        .done         (ppu_done),
        .overrun_evt  (ppu_ovr_evt)
    );

    // Next-state / arbitration. The PPU wins ties unless the CPU has waited
    // long enough to trip the starvation guard.
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        issue    = 1'b0;
        finish   = 1'b0;
        case (state)
            S_IDLE: begin
                if (cpu_pend || ppu_pend) begin
                    issue    = 1'b1;
                    state_nx = S_BUSY;
                    grant_nx = (cpu_pend && (!ppu_pend || cpu_starved)) ? G_CPU : G_PPU;
                end
            end
            S_BUSY: begin
                if (mem_ack) begin
                    finish   = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            grant <= G_CPU;
        end else begin
            state <= state_nx;
            grant <= grant_nx;
        end
    end

    // Memory-side outputs are loaded from the winning slot at grant time; the
    // slot cannot change while it is pending, so the registered copy stays
    // equal to the granted latch for the whole transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (issue) begin
            mem_req <= 1'b1;
            if (grant_nx == G_PPU) begin
                mem_we    <= ppu_lat_we;
                mem_addr  <= ppu_lat_addr;
                mem_wdata <= ppu_lat_wdata;
            end else begin
                mem_we    <= cpu_lat_we;
                mem_addr  <= cpu_lat_addr;
                mem_wdata <= cpu_lat_wdata;
            end
        end else if (finish) begin
            mem_req <= 1'b0;
        end
    end

    // Counts cycles the CPU holds a memory-bound request without owning the
    // bus; cleared only when the CPU is granted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_wait <= '0;
        end else if (issue && (grant_nx == G_CPU)) begin
            cpu_wait <= '0;
        end else if (cpu_pend && !((state == S_BUSY) && (grant == G_CPU))) begin
            cpu_wait <= sat_inc(cpu_wait);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (cpu_ovr_evt || ppu_ovr_evt) begin
            overrun <= 1'b1;
        end
    end

endmodule
`default_nettype wire
